// File: rtl/ysyx_22041211_fetch_unit_pkg.sv
// Shared definitions for the ysyx_22041211 fetch unit: reset vector and fetch state encoding.
package ysyx_22041211_fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ysyx_22041211_sync_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
module ysyx_22041211_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/ysyx_22041211_fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests to an in-order memory port,
// responses buffered in a prefetch FIFO, flush on redirect and halt on access fault.
module ysyx_22041211_fetch_unit
    import ysyx_22041211_fetch_unit_pkg::*;
#(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = ADDR_LEN'(RESET_VECTOR),
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_i,
    input  logic [ADDR_LEN-1:0] redirect_target_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_LEN-1:0] mem_rsp_data_i,
    input  logic                mem_rsp_err_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [DATA_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o,
    output logic                inst_err_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = ADDR_LEN + DATA_LEN + 1;
    localparam logic [CW:0]         DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_LEN-1:0] PC_STEP   = ADDR_LEN'(4);
    localparam logic [ADDR_LEN-1:0] PC_ALIGN  = ~ADDR_LEN'(3);

    logic [ADDR_LEN-1:0] fetch_pc;
    logic [ADDR_LEN-1:0] rsp_pc;
    logic [ADDR_LEN-1:0] hold_addr;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       out_next;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_used;
    logic                stale_req;
    logic                hold_q;
    logic                started;
    fetch_state_t        state;

    logic                fifo_full;
    logic                fifo_empty;
    logic [FW-1:0]       fifo_head;
    logic                can_issue;
    logic                accept;
    logic                rsp_keep;
    logic                rsp_drop;
    logic [ADDR_LEN-1:0] target;

    assign target      = redirect_target_i & PC_ALIGN;
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop_cnt};
    // The all-ones guard keeps the outstanding counter from wrapping when many stale
    // requests pile up behind back-to-back redirects.
    assign can_issue   = started && (state == FETCH_RUN) && !fifo_full
                         && (credit_used < DEPTH_LIM) && (outstanding != '1);

    assign mem_req_valid_o = hold_q || can_issue;
    assign mem_req_addr_o  = hold_q ? hold_addr : fetch_pc;

    assign accept   = mem_req_valid_o && mem_req_ready_i;
    assign rsp_drop = mem_rsp_valid_i && (drop_cnt != '0);
    assign rsp_keep = mem_rsp_valid_i && (drop_cnt == '0) && !redirect_i;
    assign out_next = outstanding + CW'(accept) - CW'(mem_rsp_valid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            stale_req   <= 1'b0;
            hold_q      <= 1'b0;
            started     <= 1'b0;
            state       <= FETCH_RUN;
        end else begin
            started     <= 1'b1;
            outstanding <= out_next;
            hold_q      <= mem_req_valid_o && !mem_req_ready_i;
            if (redirect_i) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc  <= target;
                rsp_pc    <= target;
                drop_cnt  <= out_next;
                stale_req <= mem_req_valid_o && !mem_req_ready_i;
                state     <= FETCH_RUN;
            end else begin
                if (accept && !stale_req) fetch_pc <= fetch_pc + PC_STEP;
                if (accept) stale_req <= 1'b0;
                drop_cnt <= drop_cnt + CW'(accept && stale_req) - CW'(rsp_drop);
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                    if (mem_rsp_err_i) state <= FETCH_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_req_valid_o && !mem_req_ready_i) hold_addr <= mem_req_addr_o;
    end

    ysyx_22041211_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (inst_ready_i),
        .flush (redirect_i),
        .din   ({rsp_pc, mem_rsp_data_i, mem_rsp_err_i}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Outputs idle at their reset values whenever the FIFO holds nothing.
    assign inst_valid_o = !fifo_empty;
    assign inst_pc_o    = fifo_empty ? RESET_PC : fifo_head[FW-1 -: ADDR_LEN];
    assign inst_o       = fifo_empty ? '0 : fifo_head[DATA_LEN:1];
    assign inst_err_o   = !fifo_empty && fifo_head[0];

endmodule
